// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline forwarding logic: redirection bus
// bit positions, the hard-wired zero register and the select encoder.
package mips_pkg;

  localparam int REDIR_A_ALU = 0;
  localparam int REDIR_A_MEM = 1;
  localparam int REDIR_B_ALU = 2;
  localparam int REDIR_B_MEM = 3;

  localparam int REG_ZERO = 0;

  // The nearer producer (EX) wins, so each operand selects at most one source.
  function automatic logic [3:0] redir_sel(input logic ex_hit_a, input logic mem_hit_a,
                                           input logic ex_hit_b, input logic mem_hit_b);
    logic [3:0] sel;
    sel              = '0;
    sel[REDIR_A_ALU] = ex_hit_a;
    sel[REDIR_A_MEM] = mem_hit_a && !ex_hit_a;
    sel[REDIR_B_ALU] = ex_hit_b;
    sel[REDIR_B_MEM] = mem_hit_b && !ex_hit_b;
    return sel;
  endfunction

endpackage

// File: rtl/redirection_ctrl_unit_sat_counter.sv
// Saturating up-counter that holds under pipeline freeze.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             freeze_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (!freeze_i && inc_i && (count_q != '1)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/redirection_ctrl_unit.sv
// Forwarding/hazard controller: compares the EX/MEM destinations with the ID
// sources, registers the EX operand-mux selects and requests load-use stalls.
module redirection_ctrl_unit
  import mips_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic                  id_wen,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_is_load,
  output logic [3:0]            redirection_ctrl,
  output logic                  load_use_stall,
  output logic [CNT_W-1:0]      fwd_count,
  output logic [CNT_W-1:0]      stall_count
);

  logic [3:0]            redir_q, redir_d;
  logic                  ex_wen_q, ex_wen_d;
  logic                  ex_load_q, ex_load_d;
  logic [REG_ADDR_W-1:0] ex_dest_q, ex_dest_d;
  logic                  mem_wen_q, mem_wen_d;
  logic [REG_ADDR_W-1:0] mem_dest_q, mem_dest_d;

  logic       ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
  logic       stall, bubble, fwd_inc;
  logic [3:0] sel;

  always_comb begin
    ex_hit_rs  = ex_wen_q && (ex_dest_q != REG_ADDR_W'(REG_ZERO)) && (ex_dest_q == id_rs) && id_use_rs;
    ex_hit_rt  = ex_wen_q && (ex_dest_q != REG_ADDR_W'(REG_ZERO)) && (ex_dest_q == id_rt) && id_use_rt;
    mem_hit_rs = mem_wen_q && (mem_dest_q != REG_ADDR_W'(REG_ZERO)) && (mem_dest_q == id_rs) && id_use_rs;
    mem_hit_rt = mem_wen_q && (mem_dest_q != REG_ADDR_W'(REG_ZERO)) && (mem_dest_q == id_rt) && id_use_rt;
    sel        = redir_sel(ex_hit_rs, mem_hit_rs, ex_hit_rt, mem_hit_rt);

    stall   = !freeze && !flush && id_valid && ex_load_q && (ex_hit_rs || ex_hit_rt);
    bubble  = flush || stall || !id_valid;
    fwd_inc = !freeze && !bubble && (sel != 4'b0000);

    redir_d    = redir_q;
    ex_wen_d   = ex_wen_q;
    ex_load_d  = ex_load_q;
    ex_dest_d  = ex_dest_q;
    mem_wen_d  = mem_wen_q;
    mem_dest_d = mem_dest_q;
    if (!freeze) begin
      mem_wen_d  = ex_wen_q;
      mem_dest_d = ex_dest_q;
      if (bubble) begin
        ex_wen_d  = 1'b0;
        ex_load_d = 1'b0;
        redir_d   = 4'b0000;
      end else begin
        ex_wen_d  = id_wen;
        ex_load_d = id_is_load;
        ex_dest_d = id_dest;
        redir_d   = sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redir_q    <= '0;
      ex_wen_q   <= 1'b0;
      ex_load_q  <= 1'b0;
      ex_dest_q  <= '0;
      mem_wen_q  <= 1'b0;
      mem_dest_q <= '0;
    end else begin
      redir_q    <= redir_d;
      ex_wen_q   <= ex_wen_d;
      ex_load_q  <= ex_load_d;
      ex_dest_q  <= ex_dest_d;
      mem_wen_q  <= mem_wen_d;
      mem_dest_q <= mem_dest_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_fwd_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .freeze_i (freeze),
    .inc_i    (fwd_inc),
    .count_o  (fwd_count)
  );

  // stall already excludes freeze, so each counted cycle is a real stall.
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .freeze_i (freeze),
    .inc_i    (stall),
    .count_o  (stall_count)
  );

  assign redirection_ctrl = redir_q;
  assign load_use_stall   = stall;

endmodule

// File: tb/tb_redirection_ctrl_unit.sv
// Scoreboard bench for redirection_ctrl_unit: directed instruction streams
// with hand-computed forwarding selects, stalls and counter values.
module tb_redirection_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        freeze, flush, id_valid;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic        id_use_rs, id_use_rt, id_wen, id_is_load;
  logic [3:0]  redirection_ctrl;
  logic        load_use_stall;
  logic [15:0] fwd_count, stall_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        stall;
    logic [3:0]  ctrl;
    logic [15:0] fwd;
    logic [15:0] scnt;
  } exp_t;

  exp_t sb[$];

  redirection_ctrl_unit #(.REG_ADDR_W(5), .CNT_W(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .freeze           (freeze),
    .flush            (flush),
    .id_valid         (id_valid),
    .id_rs            (id_rs),
    .id_rt            (id_rt),
    .id_use_rs        (id_use_rs),
    .id_use_rt        (id_use_rt),
    .id_wen           (id_wen),
    .id_dest          (id_dest),
    .id_is_load       (id_is_load),
    .redirection_ctrl (redirection_ctrl),
    .load_use_stall   (load_use_stall),
    .fwd_count        (fwd_count),
    .stall_count      (stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  // One ID-stage cycle: drive inputs after the falling edge and queue what the
  // stall line must read before the next rising edge and the state after it.
  task automatic cyc(input logic fz, input logic fl, input logic v,
                     input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt, input logic wen,
                     input logic [4:0] dest, input logic ld,
                     input logic es, input logic [3:0] ec,
                     input logic [15:0] ef, input logic [15:0] esc);
    exp_t e;
    @(negedge clk);
    freeze = fz; flush = fl; id_valid = v;
    id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_wen = wen; id_dest = dest; id_is_load = ld;
    e.stall = es; e.ctrl = ec; e.fwd = ef; e.scnt = esc;
    sb.push_back(e);
  endtask

  task automatic nop(input logic [15:0] ef, input logic [15:0] esc);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, ef, esc);
  endtask

  initial begin : monitor
    exp_t e;
    logic stall_s;
    forever begin
      @(negedge clk);
      #4;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        stall_s = load_use_stall;
        @(posedge clk);
        #1;
        chk("load_use_stall", {15'd0, stall_s}, {15'd0, e.stall});
        chk("redirection_ctrl", {12'd0, redirection_ctrl}, {12'd0, e.ctrl});
        chk("fwd_count", fwd_count, e.fwd);
        chk("stall_count", stall_count, e.scnt);
      end
    end
  end

  initial begin : driver
    int guard;
    rst_n = 1'b0; freeze = 0; flush = 0; id_valid = 0;
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_wen = 0; id_dest = 0; id_is_load = 0;
    #2;
    chk("reset_ctrl", {12'd0, redirection_ctrl}, 16'd0);
    chk("reset_fwd", fwd_count, 16'd0);
    chk("reset_stall_cnt", stall_count, 16'd0);
    chk("reset_stall", {15'd0, load_use_stall}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // add $3,$1,$2 ; sub $4,$3,$5
    cyc(0,0,1, 1,2, 1,1, 1,3, 0,  0, 4'b0000, 0, 0);
    cyc(0,0,1, 3,5, 1,1, 1,4, 0,  0, 4'b0001, 1, 0);
    nop(1, 0);
    nop(1, 0);

    // add $3 ; nop ; or $6,$7,$3
    cyc(0,0,1, 1,2, 1,1, 1,3, 0,  0, 4'b0000, 1, 0);
    nop(1, 0);
    cyc(0,0,1, 7,3, 1,1, 1,6, 0,  0, 4'b1000, 2, 0);
    // add $3 ; add $3 ; and $8,$3,$3
    cyc(0,0,1, 1,2, 1,1, 1,3, 0,  0, 4'b0000, 2, 0);
    cyc(0,0,1, 1,2, 1,1, 1,3, 0,  0, 4'b0000, 2, 0);
    cyc(0,0,1, 3,3, 1,1, 1,8, 0,  0, 4'b0101, 3, 0);
    nop(3, 0);
    nop(3, 0);

    // lw $2,0($1) ; add $4,$2,$2 (stalled once, then forwarded from MEM)
    cyc(0,0,1, 1,0, 1,0, 1,2, 1,  0, 4'b0000, 3, 0);
    cyc(0,0,1, 2,2, 1,1, 1,4, 0,  1, 4'b0000, 3, 1);
    cyc(0,0,1, 2,2, 1,1, 1,4, 0,  0, 4'b1010, 4, 1);
    nop(4, 1);
    nop(4, 1);

    // $zero never matches; unused rt never matches
    cyc(0,0,1, 1,2, 1,1, 1,0, 0,  0, 4'b0000, 4, 1);
    cyc(0,0,1, 0,0, 1,1, 1,5, 0,  0, 4'b0000, 4, 1);
    cyc(0,0,1, 1,2, 1,1, 1,9, 0,  0, 4'b0000, 4, 1);
    cyc(0,0,1, 1,9, 1,0, 1,10,0,  0, 4'b0000, 4, 1);
    nop(4, 1);
    nop(4, 1);

    // flush beats a load-use hazard: no stall, bubble issued
    cyc(0,0,1, 1,0, 1,0, 1,2, 1,  0, 4'b0000, 4, 1);
    cyc(0,1,1, 2,2, 1,1, 1,4, 0,  0, 4'b0000, 4, 1);
    nop(4, 1);

    // freeze for three cycles in the middle of a dependency chain
    cyc(0,0,1, 1,2, 1,1, 1,3, 0,  0, 4'b0000, 4, 1);
    cyc(0,0,1, 3,5, 1,1, 1,4, 0,  0, 4'b0001, 5, 1);
    for (int i = 0; i < 3; i++)
      cyc(1,0,1, 4,3, 1,1, 1,7, 0,  0, 4'b0001, 5, 1);
    cyc(0,0,1, 4,3, 1,1, 1,7, 0,  0, 4'b1001, 6, 1);

    // async reset between edges, then state must be clean
    @(negedge clk);
    id_valid = 0; freeze = 0; flush = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ctrl", {12'd0, redirection_ctrl}, 16'd0);
    chk("async_rst_fwd", fwd_count, 16'd0);
    chk("async_rst_stall_cnt", stall_count, 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // or $9,$7,$4 would have hit pre-reset EX ($7); add $10,$9,$9 forwards
    cyc(0,0,1, 7,4, 1,1, 1,9, 0,  0, 4'b0000, 0, 0);
    cyc(0,0,1, 9,9, 1,1, 1,10,0,  0, 4'b0101, 1, 0);
    nop(1, 0);

    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0 entries left", sb.size());
    end
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
